// File: rtl/regfile_write_sched_if.sv
// Write-port bundle between N_REQ requesters, the scheduler and the register file.
// master = requester/observer side, slave = scheduler side.
interface regfile_write_sched_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    write;
    logic [ADDR_W-1:0]       address;
    logic [DATA_W-1:0]       data;
    logic                    init_done;

    modport master (
        output req, req_addr, req_data,
        input  gnt, write, address, data, init_done
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, write, address, data, init_done
    );
endinterface

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler: clears all DEPTH registers after reset, then
// round-robin arbitrates N_REQ requesters. Define REG0_ZERO_EN to make register 0 read-only zero.
module regfile_write_sched #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_write_sched_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [0:0] {CLEAR, RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              init_done_q, init_done_d;
    logic [N_REQ-1:0]  gnt_p1, gnt_d;
    logic              vld_p1, vld_d;
    logic [ADDR_W-1:0] addr_p1, addr_d;
    logic [DATA_W-1:0] data_p1, data_d;

    // p0: cyclic search from rr_ptr; a requester seeing its grant this cycle is masked
    logic [N_REQ-1:0]  elig_p0;
    logic              found_p0;
    logic [PTR_W-1:0]  win_p0;
    logic [ADDR_W-1:0] win_addr_p0;
    logic [DATA_W-1:0] win_data_p0;
    logic [PTR_W:0]    idx_p0;

    assign elig_p0 = bus.req & ~gnt_p1;

    always_comb begin
        found_p0    = 1'b0;
        win_p0      = '0;
        idx_p0      = '0;
        win_addr_p0 = '0;
        win_data_p0 = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_p0 = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx_p0 >= (PTR_W+1)'(N_REQ))
                idx_p0 = idx_p0 - (PTR_W+1)'(N_REQ);
            if (!found_p0 && elig_p0[idx_p0[PTR_W-1:0]]) begin
                found_p0 = 1'b1;
                win_p0   = idx_p0[PTR_W-1:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win_p0 == PTR_W'(i)) begin
                win_addr_p0 = bus.req_addr[i*ADDR_W +: ADDR_W];
                win_data_p0 = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        init_done_d = init_done_q;
        gnt_d       = '0;
        vld_d       = 1'b0;
        addr_d      = addr_p1;
        data_d      = data_p1;
        case (state_q)
            CLEAR: begin
                vld_d     = 1'b1;
                addr_d    = clr_cnt_q;
                data_d    = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH-1))
                    state_d = RUN;
            end
            RUN: begin
                init_done_d = 1'b1;
                if (found_p0) begin
                    gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_p0;
                    rr_ptr_d = (win_p0 == PTR_W'(N_REQ-1)) ? '0 : win_p0 + 1'b1;
`ifdef REG0_ZERO_EN
                    if (win_addr_p0 != '0) begin
                        vld_d  = 1'b1;
                        addr_d = win_addr_p0;
                        data_d = win_data_p0;
                    end
`else
                    vld_d  = 1'b1;
                    addr_d = win_addr_p0;
                    data_d = win_data_p0;
`endif
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // p1: registered write port and grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            init_done_q <= 1'b0;
            gnt_p1      <= '0;
            vld_p1      <= 1'b0;
            addr_p1     <= '0;
            data_p1     <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            init_done_q <= init_done_d;
            gnt_p1      <= gnt_d;
            vld_p1      <= vld_d;
            addr_p1     <= addr_d;
            data_p1     <= data_d;
        end
    end

    assign bus.gnt       = gnt_p1;
    assign bus.write     = vld_p1;
    assign bus.address   = addr_p1;
    assign bus.data      = data_p1;
    assign bus.init_done = init_done_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: clear sequence, round-robin grants, wrap-around,
// grant masking, mid-clear reset and the register-0 behaviour selected by REG0_ZERO_EN.
module tb_regfile_write_sched;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   vecs  = 0;
    int   errs  = 0;

    always #5 clk = ~clk;

    regfile_write_sched_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_sched #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic w, input logic [3:0] a,
                              input logic [15:0] d, input logic [3:0] g, input logic done);
        check_vec({tag, ".write"},     32'(bus.write),     32'(w));
        check_vec({tag, ".address"},   32'(bus.address),   32'(a));
        check_vec({tag, ".data"},      32'(bus.data),      32'(d));
        check_vec({tag, ".gnt"},       32'(bus.gnt),       32'(g));
        check_vec({tag, ".init_done"}, 32'(bus.init_done), 32'(done));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic run_clear(input string tag, input int upto);
        for (int i = 0; i <= upto; i++) begin
            tick();
            check_port($sformatf("%s[%0d]", tag, i), 1'b1, 4'(i), 16'h0, 4'b0000, 1'b0);
        end
    endtask

    logic [3:0] exp_gnt [5];
    logic [3:0] exp_addr[5];

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        exp_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_addr = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd4};

        repeat (2) tick();
        check_port("reset", 1'b0, 4'h0, 16'h0, 4'b0000, 1'b0);

        // clear sequence, then idle with init_done set
        reset = 1'b1;
        run_clear("clear", 15);
        tick();
        check_port("clear_done", 1'b0, 4'hF, 16'h0, 4'b0000, 1'b1);

        // single request from requester 0
        bus.req = 4'b0001;
        set_req(0, 4'd3, 16'd10);
        tick();
        check_port("single", 1'b1, 4'd3, 16'd10, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        tick();
        check_port("single_idle", 1'b0, 4'd3, 16'd10, 4'b0000, 1'b1);

        // requester 3 alone brings rr_ptr back to 0
        bus.req = 4'b1000;
        set_req(3, 4'hE, 16'h0EEE);
        tick();
        check_port("req3", 1'b1, 4'hE, 16'h0EEE, 4'b1000, 1'b1);
        bus.req = 4'b0000;
        tick();
        check_port("req3_idle", 1'b0, 4'hE, 16'h0EEE, 4'b0000, 1'b1);

        // all four held: strict rotation
        for (int i = 0; i < 4; i++) set_req(i, 4'(4 + i), 16'(16'h100 + i));
        bus.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            check_port($sformatf("rr[%0d]", n), 1'b1, exp_addr[n],
                       16'h100 + 16'(exp_addr[n] - 4'd4), exp_gnt[n], 1'b1);
        end
        bus.req = 4'b0000;
        tick();
        check_port("rr_idle", 1'b0, 4'd4, 16'h100, 4'b0000, 1'b1);

        // wrap-around: grant 2, then 3 ahead of 0
        bus.req = 4'b0100;
        set_req(2, 4'hA, 16'h0AAA);
        tick();
        check_port("wrap_g2", 1'b1, 4'hA, 16'h0AAA, 4'b0100, 1'b1);
        bus.req = 4'b1001;
        set_req(3, 4'd9, 16'h0055);
        set_req(0, 4'd3, 16'd7);
        tick();
        check_port("wrap_g3", 1'b1, 4'd9, 16'h0055, 4'b1000, 1'b1);
        bus.req = 4'b0001;
        tick();
        check_port("wrap_g0", 1'b1, 4'd3, 16'd7, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        tick();
        check_port("wrap_idle", 1'b0, 4'd3, 16'd7, 4'b0000, 1'b1);

        // write to address 0
        bus.req = 4'b0010;
        set_req(1, 4'd0, 16'd7);
        tick();
`ifdef REG0_ZERO_EN
        check_port("reg0", 1'b0, 4'd3, 16'd7, 4'b0010, 1'b1);
`else
        check_port("reg0", 1'b1, 4'd0, 16'd7, 4'b0010, 1'b1);
`endif
        bus.req = 4'b0000;
        tick();
`ifdef REG0_ZERO_EN
        check_port("reg0_idle", 1'b0, 4'd3, 16'd7, 4'b0000, 1'b1);
`else
        check_port("reg0_idle", 1'b0, 4'd0, 16'd7, 4'b0000, 1'b1);
`endif

        // held req with new data is masked for one cycle after its grant
        bus.req = 4'b0001;
        set_req(0, 4'd1, 16'h0011);
        tick();
        check_port("hold_g1", 1'b1, 4'd1, 16'h0011, 4'b0001, 1'b1);
        set_req(0, 4'd2, 16'h0022);
        tick();
        check_port("hold_mask", 1'b0, 4'd1, 16'h0011, 4'b0000, 1'b1);
        tick();
        check_port("hold_g2", 1'b1, 4'd2, 16'h0022, 4'b0001, 1'b1);
        bus.req = 4'b0000;
        tick();

        // reset mid-clear at address 7, then full restart
        reset = 1'b0;
        #1;
        check_port("rst_run", 1'b0, 4'h0, 16'h0, 4'b0000, 1'b0);
        reset = 1'b1;
        run_clear("clear2", 7);
        reset = 1'b0;
        #1;
        check_port("rst_clear", 1'b0, 4'h0, 16'h0, 4'b0000, 1'b0);
        reset = 1'b1;
        run_clear("clear3", 15);
        tick();
        check_port("clear3_done", 1'b0, 4'hF, 16'h0, 4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
